multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 63 ++++++
 rtl/multicycle_ctrl_if.sv | 38 +++
 rtl/multicycle_ctrl_decode.sv | 80 ++++++++
 rtl/multicycle_ctrl.sv | 114 +++++++++++
 tb/tb_multicycle_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller: state enum,
// opcode constants, ALU/mux select encodings and the decoded control bundle.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_XOR   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic       sign_zero;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       trap;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode/mem_ready in, datapath controls out.
interface multicycle_ctrl_if #(
  parameter int OPCODE_W = 6
);
  logic [OPCODE_W-1:0] Opcode;
  logic                mem_ready;
  logic                PCWrite;
  logic                PCWriteCond;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                IRWrite;
  logic                MemtoReg;
  logic                RegWrite;
  logic                RegDst;
  logic                ALUSrcA;
  logic                SignZero;
  logic                BranchNE;
  logic [1:0]          PCSource;
  logic [1:0]          ALUOp;
  logic [1:0]          ALUSrcB;
  logic                trap;
  logic [3:0]          state_o;

  modport master (
    input  Opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegWrite, RegDst, ALUSrcA, SignZero, BranchNE, PCSource, ALUOp,
           ALUSrcB, trap, state_o
  );

  modport slave (
    output Opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegWrite, RegDst, ALUSrcA, SignZero, BranchNE, PCSource, ALUOp,
           ALUSrcB, trap, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// State-to-control decode for the multicycle controller (purely combinational).
// mem_ok gates the fetch-side writes while a memory access is still pending.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ok,
  input  logic   is_bne,
  input  logic   is_xori,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = mem_ok;
        ctrl.pc_write  = mem_ok;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_ne     = is_bne;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_IMMEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = is_xori ? ALUOP_XOR : ALUOP_ADD;
        ctrl.sign_zero = is_xori;
      end
      S_IMMWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_TRAP: begin
        ctrl.trap = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: holds the state and latched-opcode registers.
// Define CTRL_MEM_HANDSHAKE_EN to stall fetch/memory states on mem_ready.
//
// state    | meaning
// S_FETCH  | read instruction, PC += 4
// S_DECODE | latch opcode, dispatch
// S_MEMADR | compute lw/sw address
// S_MEMRD  | memory read (lw)
// S_MEMWB  | write loaded word to rt
// S_MEMWR  | memory write (sw)
// S_EXEC   | R-type ALU op
// S_ALUWB  | write ALU result to rd
// S_BRANCH | beq/bne compare and conditional PC update
// S_JUMP   | PC <= jump target
// S_IMMEX  | addi/xori ALU op
// S_IMMWB  | write immediate result to rt
// S_TRAP   | illegal opcode, parked until reset
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPCODE_W     = 6,
  parameter int ILLEGAL_TRAP = 1
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_ctrl_if.master   bus
);

  if (OPCODE_W < 6) begin : g_bad_opcode_w
    $error("multicycle_ctrl: OPCODE_W must be at least 6");
  end

  state_t              state;
  logic [OPCODE_W-1:0] opcode_q;
  logic                mem_ok;
  ctrl_t               ctrl;

  function automatic logic is_op(input logic [OPCODE_W-1:0] v, input logic [5:0] c);
    return v == OPCODE_W'(c);
  endfunction

`ifdef CTRL_MEM_HANDSHAKE_EN
  assign mem_ok = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_ok           = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      opcode_q <= '0;
    end else begin
      case (state)
        S_FETCH:  if (mem_ok) state <= S_DECODE;
        S_DECODE: begin
          opcode_q <= bus.Opcode;
          if (is_op(bus.Opcode, OP_RTYPE))
            state <= S_EXEC;
          else if (is_op(bus.Opcode, OP_LW) || is_op(bus.Opcode, OP_SW))
            state <= S_MEMADR;
          else if (is_op(bus.Opcode, OP_BEQ) || is_op(bus.Opcode, OP_BNE))
            state <= S_BRANCH;
          else if (is_op(bus.Opcode, OP_J))
            state <= S_JUMP;
          else if (is_op(bus.Opcode, OP_XORI) || is_op(bus.Opcode, OP_ADDI))
            state <= S_IMMEX;
          else
            state <= (ILLEGAL_TRAP != 0) ? S_TRAP : S_FETCH;
        end
        S_MEMADR: state <= is_op(opcode_q, OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ok) state <= S_MEMWB;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  if (mem_ok) state <= S_FETCH;
        S_EXEC:   state <= S_ALUWB;
        S_ALUWB:  state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_JUMP:   state <= S_FETCH;
        S_IMMEX:  state <= S_IMMWB;
        S_IMMWB:  state <= S_FETCH;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_FETCH;
      endcase
    end
  end

  multicycle_ctrl_decode u_decode (
    .state   (state),
    .mem_ok  (mem_ok),
    .is_bne  (is_op(opcode_q, OP_BNE)),
    .is_xori (is_op(opcode_q, OP_XORI)),
    .ctrl    (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.ior_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.SignZero    = ctrl.sign_zero;
  assign bus.BranchNE    = ctrl.branch_ne;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.trap        = ctrl.trap;
  assign bus.state_o     = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one instance traps on illegal opcodes,
// a second (ILLEGAL_TRAP=0) shares its inputs and returns to fetch instead.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic       rdy = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.OPCODE_W(6)) if1 ();
  multicycle_ctrl_if #(.OPCODE_W(6)) if0 ();

  assign if1.Opcode    = op;
  assign if1.mem_ready = rdy;
  assign if0.Opcode    = op;
  assign if0.mem_ready = rdy;

  multicycle_ctrl #(.OPCODE_W(6), .ILLEGAL_TRAP(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.master));
  multicycle_ctrl #(.OPCODE_W(6), .ILLEGAL_TRAP(0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.master));

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,
  //  RegDst,ALUSrcA,SignZero,BranchNE,PCSource,ALUOp,ALUSrcB,trap}
  wire [18:0] o1 = {if1.PCWrite, if1.PCWriteCond, if1.IorD, if1.MemRead,
                    if1.MemWrite, if1.IRWrite, if1.MemtoReg, if1.RegWrite,
                    if1.RegDst, if1.ALUSrcA, if1.SignZero, if1.BranchNE,
                    if1.PCSource, if1.ALUOp, if1.ALUSrcB, if1.trap};

  localparam logic [18:0] E_FETCH  = 19'b1_0_0_1_0_1_0_0_0_0_0_0_00_00_01_0;
  localparam logic [18:0] E_FSTALL = 19'b0_0_0_1_0_0_0_0_0_0_0_0_00_00_01_0;
  localparam logic [18:0] E_DECODE = 19'b0_0_0_0_0_0_0_0_0_0_0_0_00_00_11_0;
  localparam logic [18:0] E_MEMADR = 19'b0_0_0_0_0_0_0_0_0_1_0_0_00_00_10_0;
  localparam logic [18:0] E_MEMRD  = 19'b0_0_1_1_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [18:0] E_MEMWB  = 19'b0_0_0_0_0_0_1_1_0_0_0_0_00_00_00_0;
  localparam logic [18:0] E_MEMWR  = 19'b0_0_1_0_1_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [18:0] E_EXEC   = 19'b0_0_0_0_0_0_0_0_0_1_0_0_00_10_00_0;
  localparam logic [18:0] E_ALUWB  = 19'b0_0_0_0_0_0_0_1_1_0_0_0_00_00_00_0;
  localparam logic [18:0] E_BEQ    = 19'b0_1_0_0_0_0_0_0_0_1_0_0_01_01_00_0;
  localparam logic [18:0] E_BNE    = 19'b0_1_0_0_0_0_0_0_0_1_0_1_01_01_00_0;
  localparam logic [18:0] E_JUMP   = 19'b1_0_0_0_0_0_0_0_0_0_0_0_10_00_00_0;
  localparam logic [18:0] E_XORI   = 19'b0_0_0_0_0_0_0_0_0_1_1_0_00_11_10_0;
  localparam logic [18:0] E_ADDI   = 19'b0_0_0_0_0_0_0_0_0_1_0_0_00_00_10_0;
  localparam logic [18:0] E_IMMWB  = 19'b0_0_0_0_0_0_0_1_0_0_0_0_00_00_00_0;
  localparam logic [18:0] E_TRAP   = 19'b0_0_0_0_0_0_0_0_0_0_0_0_00_00_00_1;

`ifdef CTRL_MEM_HANDSHAKE_EN
  localparam logic TBL_RDY = 1'b1;
`else
  localparam logic TBL_RDY = 1'b0;
`endif

  typedef struct {
    logic [5:0]  op;
    state_t      st1;
    state_t      st0;
    logic [18:0] out1;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic [5:0] o, input state_t s1, input state_t s0,
                     input logic [18:0] e);
    vec_t v;
    v.op = o; v.st1 = s1; v.st0 = s0; v.out1 = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    // lw; opcode changed after decode to prove the latched copy is used
    add(6'b000000, S_FETCH,  S_FETCH,  E_FETCH);
    add(OP_LW,     S_DECODE, S_DECODE, E_DECODE);
    add(6'b111111, S_MEMADR, S_MEMADR, E_MEMADR);
    add(6'b111111, S_MEMRD,  S_MEMRD,  E_MEMRD);
    add(6'b000000, S_MEMWB,  S_MEMWB,  E_MEMWB);
    add(6'b000000, S_FETCH,  S_FETCH,  E_FETCH);
    add(OP_SW,     S_DECODE, S_DECODE, E_DECODE);
    add(OP_LW,     S_MEMADR, S_MEMADR, E_MEMADR);
    add(OP_LW,     S_MEMWR,  S_MEMWR,  E_MEMWR);
    add(6'b000000, S_FETCH,  S_FETCH,  E_FETCH);
    add(OP_RTYPE,  S_DECODE, S_DECODE, E_DECODE);
    add(6'b000000, S_EXEC,   S_EXEC,   E_EXEC);
    add(6'b000000, S_ALUWB,  S_ALUWB,  E_ALUWB);
    add(6'b000000, S_FETCH,  S_FETCH,  E_FETCH);
    add(OP_BEQ,    S_DECODE, S_DECODE, E_DECODE);
    add(OP_BNE,    S_BRANCH, S_BRANCH, E_BEQ);
    add(6'b000000, S_FETCH,  S_FETCH,  E_FETCH);
    add(OP_BNE,    S_DECODE, S_DECODE, E_DECODE);
    add(OP_BEQ,    S_BRANCH, S_BRANCH, E_BNE);
    add(6'b000000, S_FETCH,  S_FETCH,  E_FETCH);
    add(OP_J,      S_DECODE, S_DECODE, E_DECODE);
    add(6'b000000, S_JUMP,   S_JUMP,   E_JUMP);
    add(6'b000000, S_FETCH,  S_FETCH,  E_FETCH);
    add(OP_XORI,   S_DECODE, S_DECODE, E_DECODE);
    add(OP_ADDI,   S_IMMEX,  S_IMMEX,  E_XORI);
    add(6'b000000, S_IMMWB,  S_IMMWB,  E_IMMWB);
    add(6'b000000, S_FETCH,  S_FETCH,  E_FETCH);
    add(OP_ADDI,   S_DECODE, S_DECODE, E_DECODE);
    add(OP_XORI,   S_IMMEX,  S_IMMEX,  E_ADDI);
    add(6'b000000, S_IMMWB,  S_IMMWB,  E_IMMWB);
    add(6'b000000, S_FETCH,  S_FETCH,  E_FETCH);
    add(6'b111111, S_DECODE, S_DECODE, E_DECODE);
    add(6'b000000, S_TRAP,   S_FETCH,  E_TRAP);
    add(OP_J,      S_TRAP,   S_DECODE, E_TRAP);
    add(6'b000000, S_TRAP,   S_JUMP,   E_TRAP);

    rdy   = TBL_RDY;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    foreach (tbl[i]) begin
      op = tbl[i].op;
      @(negedge clk);
      check($sformatf("row%0d state", i), 19'(if1.state_o), 19'(tbl[i].st1));
      check($sformatf("row%0d outputs", i), o1, tbl[i].out1);
      check($sformatf("row%0d state_notrap", i), 19'(if0.state_o), 19'(tbl[i].st0));
      step();
    end

    @(negedge clk);
    check("trap held", 19'(if1.state_o), 19'(S_TRAP));

    // reset escapes the trap; first cycle after release shows fetch outputs
    do_reset();
    @(negedge clk);
    check("post-reset state", 19'(if1.state_o), 19'(S_FETCH));
    check("post-reset outputs", o1, E_FETCH);

    // reset during EXEC: back to fetch with no register write
    op = OP_RTYPE;
    step();
    step();
    @(negedge clk);
    check("exec state", 19'(if1.state_o), 19'(S_EXEC));
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("exec reset state", 19'(if1.state_o), 19'(S_FETCH));
    check("exec reset regwrite", 19'(if1.RegWrite), 19'(0));
    step();
    @(negedge clk);
    check("exec reset decode", 19'(if1.state_o), 19'(S_DECODE));
    check("exec reset regwrite2", 19'(if1.RegWrite), 19'(0));

`ifdef CTRL_MEM_HANDSHAKE_EN
    rdy = 1'b0;
    do_reset();
    @(negedge clk);
    check("hs fetch stall", o1, E_FSTALL);
    step();
    @(negedge clk);
    check("hs fetch held", 19'(if1.state_o), 19'(S_FETCH));
    rdy = 1'b1;
    #1;
    check("hs fetch ready", o1, E_FETCH);
    step();
    op = OP_LW;
    step();
    step();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("hs memrd hold%0d state", k), 19'(if1.state_o), 19'(S_MEMRD));
      check($sformatf("hs memrd hold%0d out", k), o1, E_MEMRD);
      step();
    end
    rdy = 1'b1;
    @(negedge clk);
    check("hs memrd release", 19'(if1.state_o), 19'(S_MEMRD));
    step();
    @(negedge clk);
    check("hs memwb", 19'(if1.state_o), 19'(S_MEMWB));
    step();
    step();
    op = OP_SW;
    step();
    step();
    rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("hs memwr hold%0d", k), 19'(if1.state_o), 19'(S_MEMWR));
      step();
    end
    rdy = 1'b1;
    step();
    @(negedge clk);
    check("hs memwr done", 19'(if1.state_o), 19'(S_FETCH));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
